// File: rtl/event_blinker_pkg.sv
// Shared definitions for the event blinker: FSM state encodings, default LED
// timing constants, and the timer width helper.
package event_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

  localparam int unsigned DEFAULT_ON_CYCLES   = 25_000_000;
  localparam int unsigned DEFAULT_OFF_CYCLES  = 25_000_000;
  localparam int unsigned DEFAULT_MAX_PENDING = 7;

  // Width of the phase down-counter; clamped to 1 so one-cycle phases still get a real register.
  function automatic int unsigned timer_width(input int unsigned on_c, input int unsigned off_c);
    int unsigned m;
    m = (on_c > off_c) ? on_c : off_c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/event_blinker_cycle_timer.sv
// Loadable down-counter for blink phase timing. Load wins over counting;
// the count holds at zero until reloaded.
module cycle_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event strobes into visible LED blinks (ON high, OFF low per
// event); events arriving mid-blink queue in a saturating counter and replay back-to-back.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int unsigned OFF_CYCLES  = DEFAULT_OFF_CYCLES,
  parameter int unsigned MAX_PENDING = DEFAULT_MAX_PENDING
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               event_in,
  input  logic                               clear,
  output logic                               led_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic                               overflow
);

  localparam int unsigned TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam int unsigned PW = $clog2(MAX_PENDING + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] MAX_CNT  = PW'(MAX_PENDING);

  blink_state_e  state;
  logic          timer_zero;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          start_req;
  logic          consume;
  logic [PW-1:0] pend_next;
  logic          pend_drop;

  // A new blink may start from IDLE at once, or from OFF only when its gap has elapsed.
  assign start_req = event_in | (pending_cnt != '0);
  assign consume   = ~clear & start_req &
                     ((state == ST_IDLE) | ((state == ST_OFF) & timer_zero));

  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    if (clear) begin
      timer_load  = 1'b1;
      timer_value = '0;
    end else if (consume) begin
      timer_load  = 1'b1;
      timer_value = ON_LOAD;
    end else if ((state == ST_ON) && timer_zero) begin
      timer_load  = 1'b1;
      timer_value = OFF_LOAD;
    end
  end

  // Arrival and consumption in the same cycle cancel: the event passes straight through.
  always_comb begin
    pend_next = pending_cnt;
    pend_drop = 1'b0;
    if (event_in && !consume) begin
      if (pending_cnt == MAX_CNT) begin
        pend_drop = 1'b1;
      end else begin
        pend_next = pending_cnt + 1'b1;
      end
    end else if (!event_in && consume) begin
      pend_next = pending_cnt - 1'b1;
    end
  end

  cycle_timer #(
    .TW(TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      led_out     <= 1'b0;
      busy        <= 1'b0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      state       <= ST_IDLE;
      led_out     <= 1'b0;
      busy        <= 1'b0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      pending_cnt <= pend_next;
      overflow    <= pend_drop;
      case (state)
        ST_IDLE: begin
          if (consume) begin
            state   <= ST_ON;
            led_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_ON: begin
          if (timer_zero) begin
            state   <= ST_OFF;
            led_out <= 1'b0;
          end
        end
        ST_OFF: begin
          if (timer_zero) begin
            if (consume) begin
              state   <= ST_ON;
              led_out <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          led_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker: schedule-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized event traffic.
module tb_event_blinker;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 3;
  localparam int PW   = $clog2(MAXP + 1);

  logic          clk;
  logic          rst_n;
  logic          event_in;
  logic          clear;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending_cnt;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  event_blinker #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .event_in   (event_in),
    .clear      (clear),
    .led_out    (led_out),
    .busy       (busy),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // A blink started at edge s is lit after edges s..s+ON-1, dark until s+ON+OFF-1,
  // and edge s+ON+OFF is the next opportunity to start another one.
  int m_k     = 0;
  int m_start = 0;
  int m_pend  = 0;
  bit m_active = 0;
  bit m_ovf    = 0;

  always @(posedge clk or negedge rst_n) begin
    bit can_start;
    if (!rst_n) begin
      m_active = 0;
      m_pend   = 0;
      m_ovf    = 0;
    end else begin
      m_k++;
      m_ovf = 0;
      if (clear) begin
        m_active = 0;
        m_pend   = 0;
      end else begin
        can_start = !m_active || (m_k - m_start == ON + OFF);
        if (can_start && (event_in || m_pend > 0)) begin
          m_active = 1;
          m_start  = m_k;
          if (!event_in) m_pend--;
        end else begin
          if (can_start) m_active = 0;
          if (event_in) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_led", int'(led_out), int'(m_active && (m_k - m_start) < ON));
      chk("cmp_busy", int'(busy), int'(m_active));
      chk("cmp_pending", int'(pending_cnt), m_pend);
      chk("cmp_overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- driver / recorder ----------------
  logic [31:0] led_bits, busy_bits;
  int max_pend, ovf_cnt, rises;
  logic prev_led;
  int pend_at[64];

  task automatic step(input bit ev, input bit clr);
    event_in = ev;
    clear    = clr;
    @(negedge clk);
  endtask

  task automatic rec_reset();
    led_bits = '0; busy_bits = '0;
    max_pend = 0; ovf_cnt = 0; rises = 0;
    prev_led = led_out;
  endtask

  task automatic rec(input int idx);
    led_bits  = {led_bits[30:0], led_out};
    busy_bits = {busy_bits[30:0], busy};
    if (int'(pending_cnt) > max_pend) max_pend = int'(pending_cnt);
    if (overflow) ovf_cnt++;
    if (led_out && !prev_led) rises++;
    prev_led = led_out;
    if (idx < 64) pend_at[idx] = int'(pending_cnt);
  endtask

  // Drives events at the listed offsets over n cycles, recording after each edge.
  task automatic run_pattern(input logic [63:0] ev_mask, input int clr_at, input int n);
    rec_reset();
    for (int i = 0; i < n; i++) begin
      step(ev_mask[i], i == clr_at);
      rec(i);
    end
    event_in = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    event_in = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pending_cnt), 0);
    chk("reset_overflow", int'(overflow), 0);
    rst_n  = 1'b1;
    cmp_en = 1;
    idle(5);

    // Single pulse: 4 lit, 3 dark, then idle.
    run_pattern(64'h1, -1, 10);
    chk("s1_led_seq", int'(led_bits[9:0]), int'(10'b1111000000));
    chk("s1_busy_seq", int'(busy_bits[9:0]), int'(10'b1111111000));
    chk("s1_max_pend", max_pend, 0);
    idle(4);

    // Pulses at offsets 0,2,3: three back-to-back blinks.
    run_pattern(64'b1101, -1, 24);
    chk("s2_blinks", rises, 3);
    chk("s2_max_pend", max_pend, 2);
    chk("s2_pend_before", pend_at[6], 2);
    chk("s2_pend_dec1", pend_at[7], 1);
    chk("s2_pend_dec2", pend_at[14], 0);
    chk("s2_busy_end", int'(busy_bits[0]), 0);
    idle(4);

    // Seven consecutive pulses: saturation and three dropped events.
    run_pattern(64'h7F, -1, 32);
    chk("s3_blinks", rises, 4);
    chk("s3_overflows", ovf_cnt, 3);
    chk("s3_max_pend", max_pend, 3);
    idle(4);

    // Event coincident with OFF->ON while one is queued: count holds.
    run_pattern(64'b1000_0011, -1, 24);
    chk("s4_pend_pre", pend_at[6], 1);
    chk("s4_pend_pass", pend_at[7], 1);
    chk("s4_blinks", rises, 3);
    idle(4);

    // Clear during ON with two queued.
    run_pattern(64'b111, 3, 4);
    chk("s5_pend_pre", pend_at[2], 2);
    chk("s5_led_clr", int'(led_out), 0);
    chk("s5_busy_clr", int'(busy), 0);
    chk("s5_pend_clr", int'(pending_cnt), 0);
    run_pattern(64'h0, -1, 12);
    chk("s5_no_blink", rises, 0);
    chk("s5_no_busy", int'(busy_bits[11:0]), 0);

    // Asynchronous reset mid-blink, off the clock edge.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("s6_led_pre", int'(led_out), 1);
    chk("s6_pend_pre", int'(pending_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_led_rst", int'(led_out), 0);
    chk("s6_busy_rst", int'(busy), 0);
    chk("s6_pend_rst", int'(pending_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pattern(64'h0, -1, 12);
    chk("s6_no_blink", rises, 0);
    chk("s6_no_busy", int'(busy_bits[11:0]), 0);

    // Randomized traffic with varying density and rare clears.
    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      dens = $urandom_range(1, 7);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 9) < dens, $urandom_range(0, 149) == 0);
      end
    end
    event_in = 1'b0;
    clear    = 1'b0;
    idle(40);
    chk("end_idle_busy", int'(busy), 0);
    chk("end_idle_pend", int'(pending_cnt), 0);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
